// File: rtl/vga_timing_if.sv
// Raster timing bundle from the VGA timing generator to its consumers
// (renderer, game logic, connector pins).
interface vga_timing_if;
  logic       pix_en;
  logic [9:0] hCount;
  logic [9:0] vCount;
  logic       hSync;
  logic       vSync;
  logic       bright;
  logic       frame_tick;

  modport master (
    output pix_en,
    output hCount,
    output vCount,
    output hSync,
    output vSync,
    output bright,
    output frame_tick
  );

  modport slave (
    input pix_en,
    input hCount,
    input vCount,
    input hSync,
    input vSync,
    input bright,
    input frame_tick
  );
endinterface

// File: rtl/vga_timing_gen.sv
// 640x480 @ 60 Hz raster timing generator: pixel-enable divider, h/v counters,
// registered sync/visible flags aligned to the counters, and a per-frame strobe.
module vga_timing_gen #(
  parameter int unsigned CLK_DIV = 4,
  parameter int unsigned H_TOTAL = 800,
  parameter int unsigned V_TOTAL = 525,
  parameter int unsigned H_SYNC  = 96,
  parameter int unsigned V_SYNC  = 2,
  parameter int unsigned H_START = 144,
  parameter int unsigned H_END   = 783,
  parameter int unsigned V_START = 35,
  parameter int unsigned V_END   = 514
) (
  input  logic         clk,
  input  logic         rst,
  vga_timing_if.master vga
);

  localparam int unsigned DivW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DivW-1:0] DivLast = DivW'(CLK_DIV - 1);
  localparam logic [9:0]      HLast   = 10'(H_TOTAL - 1);
  localparam logic [9:0]      VLast   = 10'(V_TOTAL - 1);
  localparam logic [9:0]      HSyncW  = 10'(H_SYNC);
  localparam logic [9:0]      VSyncW  = 10'(V_SYNC);
  localparam logic [9:0]      HStart  = 10'(H_START);
  localparam logic [9:0]      HEnd    = 10'(H_END);
  localparam logic [9:0]      VStart  = 10'(V_START);
  localparam logic [9:0]      VEnd    = 10'(V_END);

  logic [DivW-1:0] div_q, div_d;
  logic [9:0]      h_q, h_d;
  logic [9:0]      v_q, v_d;
  logic            hsync_q, hsync_d;
  logic            vsync_q, vsync_d;
  logic            bright_q, bright_d;
  logic            tick_q, tick_d;
  logic            pix_en;

  // Pixel enable is the last system cycle of each pixel; div is 0 in reset.
  assign pix_en = (div_q == DivLast);

  // Next-state counters; flags derive from next-state counts so they line up
  // with the counts they are registered alongside.
  always_comb begin
    div_d  = (div_q == DivLast) ? '0 : div_q + 1'b1;
    h_d    = h_q;
    v_d    = v_q;
    tick_d = 1'b0;
    if (pix_en) begin
      if (h_q < HLast) begin
        h_d = h_q + 10'd1;
      end else begin
        h_d = '0;
        if (v_q < VLast) begin
          v_d = v_q + 10'd1;
        end else begin
          v_d    = '0;
          tick_d = 1'b1;
        end
      end
    end
    hsync_d  = (h_d >= HSyncW);
    vsync_d  = (v_d >= VSyncW);
    bright_d = (h_d >= HStart) && (h_d <= HEnd) && (v_d >= VStart) && (v_d <= VEnd);
  end

  // State and registered outputs; reset clears everything immediately.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_q    <= '0;
      h_q      <= '0;
      v_q      <= '0;
      hsync_q  <= 1'b0;
      vsync_q  <= 1'b0;
      bright_q <= 1'b0;
      tick_q   <= 1'b0;
    end else begin
      div_q    <= div_d;
      h_q      <= h_d;
      v_q      <= v_d;
      hsync_q  <= hsync_d;
      vsync_q  <= vsync_d;
      bright_q <= bright_d;
      tick_q   <= tick_d;
    end
  end

  assign vga.pix_en     = pix_en;
  assign vga.hCount     = h_q;
  assign vga.vCount     = v_q;
  assign vga.hSync      = hsync_q;
  assign vga.vSync      = vsync_q;
  assign vga.bright     = bright_q;
  assign vga.frame_tick = tick_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: a default-sized instance and a shrunken one share
// clock and reset; both are checked every cycle against a time-based model.
module tb_vga_timing_gen;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  vga_timing_if big_if ();
  vga_timing_if sml_if ();

  vga_timing_gen u_big (
    .clk (clk),
    .rst (rst),
    .vga (big_if)
  );

  vga_timing_gen #(
    .CLK_DIV (2),
    .H_TOTAL (10),
    .V_TOTAL (5),
    .H_SYNC  (2),
    .V_SYNC  (1),
    .H_START (3),
    .H_END   (7),
    .V_START (1),
    .V_END   (3)
  ) u_sml (
    .clk (clk),
    .rst (rst),
    .vga (sml_if)
  );

  int unsigned errors = 0;
  int unsigned checks = 0;
  int unsigned n;           // rising edges since reset released
  logic        chk_en = 1'b0;
  int unsigned last_ft;
  logic        last_ft_ok;

  always @(posedge clk or negedge rst) begin
    if (!rst) n <= 0;
    else      n <= n + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at n=%0d: got %0d, expected %0d", name, n, act, exp);
    end
  endtask

  // Expected outputs from elapsed pixels since reset release.
  task automatic compare_one(input string tag,
                             input int unsigned d, ht, vt, hs, vs, hst, he, vst, ve,
                             input logic pe, input logic [9:0] h, v,
                             input logic hsy, vsy, br, ft);
    int unsigned p, eh, ev;
    logic epe, ehs, evs, ebr, eft;
    if (!rst) begin
      eh = 0; ev = 0; epe = 0; ehs = 0; evs = 0; ebr = 0; eft = 0;
    end else begin
      p   = n / d;
      eh  = p % ht;
      ev  = (p / ht) % vt;
      epe = ((n % d) == d - 1);
      ehs = (eh >= hs);
      evs = (ev >= vs);
      ebr = (eh >= hst) && (eh <= he) && (ev >= vst) && (ev <= ve);
      eft = (p > 0) && ((n % d) == 0) && ((p % (ht * vt)) == 0);
    end
    check({tag, ".pix_en"},     32'(pe),  32'(epe));
    check({tag, ".hCount"},     32'(h),   eh);
    check({tag, ".vCount"},     32'(v),   ev);
    check({tag, ".hSync"},      32'(hsy), 32'(ehs));
    check({tag, ".vSync"},      32'(vsy), 32'(evs));
    check({tag, ".bright"},     32'(br),  32'(ebr));
    check({tag, ".frame_tick"}, 32'(ft),  32'(eft));
  endtask

  // Per-cycle compare, sampled on the falling edge.
  always @(negedge clk) begin
    if (chk_en) begin
      compare_one("big", 4, 800, 525, 96, 2, 144, 783, 35, 514,
                  big_if.pix_en, big_if.hCount, big_if.vCount,
                  big_if.hSync, big_if.vSync, big_if.bright, big_if.frame_tick);
      compare_one("sml", 2, 10, 5, 2, 1, 3, 7, 1, 3,
                  sml_if.pix_en, sml_if.hCount, sml_if.vCount,
                  sml_if.hSync, sml_if.vSync, sml_if.bright, sml_if.frame_tick);
      if (!rst) begin
        last_ft_ok = 1'b0;
      end else if (sml_if.frame_tick) begin
        if (last_ft_ok) check("sml.tick_spacing", n - last_ft, 100);
        last_ft    = n;
        last_ft_ok = 1'b1;
      end
    end
  end

  task automatic wait_n(input int unsigned target);
    int unsigned k = 0;
    while (n != target && k < 200000) begin
      @(negedge clk);
      k++;
    end
    if (n != target) begin
      check("wait_timeout", n, target);
      $display("FAIL wait_n gave up: n=%0d target=%0d", n, target);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $fatal(1, "timeout");
    end
  endtask

  task automatic release_rst();
    @(posedge clk);
    #2 rst = 1'b1;
  endtask

  // Start-of-run literal checks, valid after each reset release.
  task automatic start_checks();
    check("rel.big.tick", 32'(big_if.frame_tick), 0);
    repeat (3) @(posedge clk);
    #1;
    check("e3.big.pix_en", 32'(big_if.pix_en), 1);
    check("e3.big.hCount", 32'(big_if.hCount), 0);
    check("e3.sml.pix_en", 32'(sml_if.pix_en), 1);
    check("e3.sml.hCount", 32'(sml_if.hCount), 1);
    @(posedge clk);
    #1;
    check("e4.big.hCount", 32'(big_if.hCount), 1);
    check("e4.big.pix_en", 32'(big_if.pix_en), 0);
    check("e4.sml.hCount", 32'(sml_if.hCount), 2);
  endtask

  initial begin
    int unsigned hs_low;
    last_ft    = 0;
    last_ft_ok = 1'b0;
    #1 rst = 1'b0;
    chk_en = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    check("rst.big.hSync", 32'(big_if.hSync), 0);
    check("rst.big.hCount", 32'(big_if.hCount), 0);
    release_rst();
    start_checks();

    // Small-instance visible window and frame wrap.
    wait_n(25);
    check("n25.sml.hCount", 32'(sml_if.hCount), 2);
    check("n25.sml.bright", 32'(sml_if.bright), 0);
    wait_n(26);
    check("n26.sml.hv", {22'd0, sml_if.hCount} * 100 + 32'(sml_if.vCount), 301);
    check("n26.sml.bright", 32'(sml_if.bright), 1);
    wait_n(35);
    check("n35.sml.bright", 32'(sml_if.bright), 1);
    wait_n(36);
    check("n36.sml.bright", 32'(sml_if.bright), 0);
    wait_n(99);
    check("n99.sml.hv", {22'd0, sml_if.hCount} * 100 + 32'(sml_if.vCount), 904);
    check("n99.sml.pix_en", 32'(sml_if.pix_en), 1);
    wait_n(100);
    check("n100.sml.hv", {22'd0, sml_if.hCount} * 100 + 32'(sml_if.vCount), 0);
    check("n100.sml.tick", 32'(sml_if.frame_tick), 1);
    wait_n(101);
    check("n101.sml.tick", 32'(sml_if.frame_tick), 0);
    wait_n(200);
    check("n200.sml.tick", 32'(sml_if.frame_tick), 1);

    // Default-instance line wrap and hSync width.
    wait_n(3199);
    check("n3199.big.hCount", 32'(big_if.hCount), 799);
    check("n3199.big.vSync", 32'(big_if.vSync), 0);
    wait_n(3200);
    check("n3200.big.hCount", 32'(big_if.hCount), 0);
    check("n3200.big.vCount", 32'(big_if.vCount), 1);
    hs_low = 0;
    repeat (3200) begin
      if (!big_if.hSync) hs_low++;
      @(negedge clk);
    end
    check("line1.hsync_low", hs_low, 384);
    check("n6400.big.vCount", 32'(big_if.vCount), 2);
    check("n6400.big.vSync", 32'(big_if.vSync), 1);
    check("n6400.big.bright", 32'(big_if.bright), 0);

    // Asynchronous reset between edges, mid-line/mid-frame.
    wait_n(6430);
    @(posedge clk);
    #2;
    check("pre.sml.bright", 32'(sml_if.bright), 1);
    check("pre.big.hCount", 32'(big_if.hCount), 7);
    rst = 1'b0;
    #1;
    check("async.big.hCount", 32'(big_if.hCount), 0);
    check("async.big.vCount", 32'(big_if.vCount), 0);
    check("async.big.vSync", 32'(big_if.vSync), 0);
    check("async.sml.bright", 32'(sml_if.bright), 0);
    check("async.sml.hSync", 32'(sml_if.hSync), 0);
    check("async.sml.pix_en", 32'(sml_if.pix_en), 0);
    repeat (5) @(posedge clk);
    release_rst();
    start_checks();
    wait_n(99);
    check("r99.sml.tick", 32'(sml_if.frame_tick), 0);
    wait_n(100);
    check("r100.sml.tick", 32'(sml_if.frame_tick), 1);
    wait_n(320);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
